icache_responder: RTL and testbench
===================================

// Module: icache_responder
// PURPOSE
//  Responder side of the instruction-memory handshake driven by the fetch stage:
//  direct-mapped, read-only instruction cache. Answers imem_read/imem_address with
//  imem_resp/imem_rdata; a hit responds in the same cycle. On a miss it fetches the
//  line from physical memory over the pmem read handshake. Sits between fetch and the memory arbiter.
// PARAMETERS
//  NUM_SETS    8   number of lines; power of two, >=2
//  LINE_WORDS  8   16-bit words per line; fixed by the 128-bit pmem line, do not override
// PORTS
//  clk           in   1    clock, rising edge
//  rst           in   1    synchronous, active-high reset
//  imem_read     in   1    fetch requests the word at imem_address
//  imem_address  in   16   byte address (lc3b_word); bit 0 ignored
//  imem_resp     out  1    imem_rdata valid this cycle
//  imem_rdata    out  16   instruction word
//  pmem_read     out  1    line fill request, held until pmem_resp
//  pmem_address  out  16   line-aligned fill address, [3:0]=0
//  pmem_rdata    in   128  fill line; word k = bits [16k+15:16k]
//  pmem_resp     in   1    pmem_rdata valid; ends fill
//  miss_count    out  16   saturating count of fills started
// BEHAVIOUR
//  Address split (NUM_SETS=8): offset=addr[3:1], index=addr[6:4], tag=addr[15:7];
//   in general index width = log2(NUM_SETS), tag = the remaining upper bits.
//  Reset: all valid bits cleared; state=IDLE; pmem_read=0; pmem_address=0;
//   miss_count=0; imem_resp=0. Data/tag arrays are not cleared.
//  Reset during FILL: abort at that edge; pmem_read=0 next cycle; line stays invalid.
//   A late pmem_resp is ignored.
//  FSM, two states:
//   IDLE: hit = imem_read & valid[index] & tag match.
//    On hit: imem_resp=1 and imem_rdata=word[offset], both combinational, same cycle.
//    On imem_read & ~hit: latch {tag,index} into miss_line; pmem_address<= {tag,index,4'b0};
//     increment miss_count (holds at 16'hFFFF); next state FILL.
//    With imem_read=0: no action.
//   FILL: pmem_read=1 and imem_resp=0. Hold pmem_address constant.
//    On pmem_resp=1 at the edge: write the pmem_rdata line, the latched tag and valid=1
//     into set miss_line.index; next state IDLE.
//    The fill always completes for the latched line, even if imem_read drops or
//     imem_address changes mid-fill.
//  Latency: hit = 0 cycles (combinational). Miss: detect in cycle 0; FILL from cycle 1;
//   pmem_resp in cycle F; IDLE hit in cycle F+1.
//  imem_rdata = 16'h0000 whenever imem_resp=0 (deterministic for the bench).
//  No write port: requests for stores never arrive here; self-modifying code is not supported.
//  pmem_read never asserts in IDLE; at most one outstanding fill.
//  A request that misses in the cycle a fill completes is handled by the next IDLE cycle.
// STRUCTURE
//  lc3b_types additions: typedef logic [127:0] lc3b_line.
//   Localparams ICACHE_IDX_W and ICACHE_TAG_W are derived from NUM_SETS.
//  Sub-module icache_array: valid/tag/data storage.
//   Synchronous write with clr of the valid bits on rst; asynchronous read by index.
//  The top holds the FSM, miss-line latch, hit compare, word mux and miss counter.
// TESTING
//  1 Reset, read 0x0000 -> imem_resp=0; pmem_read=1 with pmem_address=0x0000 from the
//    next cycle; pmem_resp after 5 cycles with line word0=0x1234 -> next cycle imem_resp=1,
//    imem_rdata=0x1234; miss_count=1.
//  2 After 1, read 0x000E -> same-cycle imem_resp=1 with word7, no pmem_read;
//    read 0x0005 -> word2.
//  3 Conflict: read 0x0080 (same index 0, tag 1) -> fill at 0x0080;
//    then 0x0000 misses again; miss_count=3.
//  4 Fill for 0x0010 started; imem_address changes to 0x0200 and imem_read drops mid-fill
//    -> pmem_address stays 0x0010; set 1 valid afterwards; 0x0010 then hits.
//  5 rst asserted two cycles into a FILL -> pmem_read=0 next cycle; pmem_resp then pulsed
//    -> ignored; previously filled lines now miss.
//  6 Force miss_count to 0xFFFF via 65535 conflicting misses (or a preloaded counter)
//    -> one more miss leaves it at 0xFFFF.

Source files
------------

// File: rtl/icache_responder_pkg.sv
// Shared types and geometry for the direct-mapped, read-only instruction cache.
package icache_responder_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    localparam int unsigned ICACHE_NUM_SETS   = 8;
    localparam int unsigned ICACHE_LINE_WORDS = 8;
    localparam int unsigned ICACHE_OFF_W      = $clog2(ICACHE_LINE_WORDS);
    localparam int unsigned ICACHE_IDX_W      = $clog2(ICACHE_NUM_SETS);
    localparam int unsigned ICACHE_TAG_W      = 16 - ICACHE_IDX_W - ICACHE_OFF_W - 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } icache_state_e;

    // Select word `off` of a line; word k occupies bits [16k+15:16k].
    function automatic lc3b_word line_word(input lc3b_line line, input logic [ICACHE_OFF_W-1:0] off);
        return line[{off, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/icache_responder_array.sv
// Valid/tag/data storage: synchronous write, valid bits cleared on rst, asynchronous read.
module icache_array
    import icache_responder_pkg::*;
#(
    parameter int unsigned NUM_SETS = ICACHE_NUM_SETS,
    parameter int unsigned IDX_W    = ICACHE_IDX_W,
    parameter int unsigned TAG_W    = ICACHE_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [TAG_W-1:0] wtag,
    input  lc3b_line         wline,
    input  logic [IDX_W-1:0] ridx,
    output logic             rvalid,
    output logic [TAG_W-1:0] rtag,
    output lc3b_line         rline
);

    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    lc3b_line            line_q [NUM_SETS];

    // Valid bits: reset wins over a simultaneous fill so an aborted line stays invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[widx]  <= wtag;
            line_q[widx] <= wline;
        end
    end

    assign rvalid = valid_q[ridx];
    assign rtag   = tag_q[ridx];
    assign rline  = line_q[ridx];

endmodule

// File: rtl/icache_responder.sv
// Fetch-side instruction cache: same-cycle hits, single outstanding line fill on a miss.
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int unsigned NUM_SETS   = ICACHE_NUM_SETS,
    parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         imem_read,
    input  logic [15:0]  imem_address,
    output logic         imem_resp,
    output logic [15:0]  imem_rdata,
    output logic         pmem_read,
    output logic [15:0]  pmem_address,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  miss_count
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W = 16 - IDX_W - OFF_W - 1;

    icache_state_e state_q, state_d;

    logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
    logic             pmem_read_q, pmem_read_d;
    logic [15:0]      pmem_address_q, pmem_address_d;
    logic [15:0]      miss_cnt_q, miss_cnt_d;
    logic             fill_we_c;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    lc3b_line         rd_line;
    logic             hit_c;
    logic             unused_addr_lsb;

    // Byte address split; bit 0 selects a byte within the word and is not needed.
    assign req_off         = imem_address[OFF_W:1];
    assign req_idx         = imem_address[OFF_W+1 +: IDX_W];
    assign req_tag         = imem_address[15 -: TAG_W];
    assign unused_addr_lsb = imem_address[0];

    icache_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (fill_we_c),
        .widx   (miss_idx_q),
        .wtag   (miss_tag_q),
        .wline  (pmem_rdata),
        .ridx   (req_idx),
        .rvalid (rd_valid),
        .rtag   (rd_tag),
        .rline  (rd_line)
    );

    // Hits only count in IDLE; during a fill the requester simply waits.
    assign hit_c      = (state_q == ST_IDLE) && imem_read && rd_valid && (rd_tag == req_tag);
    assign imem_resp  = hit_c;
    assign imem_rdata = hit_c ? rd_line[{req_off, 4'b0000} +: 16] : 16'h0000;

    assign pmem_read    = pmem_read_q;
    assign pmem_address = pmem_address_q;
    assign miss_count   = miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            miss_tag_q     <= '0;
            miss_idx_q     <= '0;
            pmem_read_q    <= 1'b0;
            pmem_address_q <= 16'h0000;
            miss_cnt_q     <= 16'h0000;
        end else begin
            state_q        <= state_d;
            miss_tag_q     <= miss_tag_d;
            miss_idx_q     <= miss_idx_d;
            pmem_read_q    <= pmem_read_d;
            pmem_address_q <= pmem_address_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

    // Next state: a miss latches the line and starts a fill that runs to completion.
    always_comb begin
        state_d        = state_q;
        miss_tag_d     = miss_tag_q;
        miss_idx_d     = miss_idx_q;
        pmem_read_d    = pmem_read_q;
        pmem_address_d = pmem_address_q;
        miss_cnt_d     = miss_cnt_q;
        fill_we_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (imem_read && !hit_c) begin
                    miss_tag_d     = req_tag;
                    miss_idx_d     = req_idx;
                    pmem_address_d = {req_tag, req_idx, {(OFF_W + 1){1'b0}}};
                    pmem_read_d    = 1'b1;
                    if (miss_cnt_q != 16'hFFFF) begin
                        miss_cnt_d = miss_cnt_q + 16'd1;
                    end
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (pmem_resp) begin
                    fill_we_c   = 1'b1;
                    pmem_read_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed scenarios plus random traffic against a line-level model.
module tb_icache_responder;
    import icache_responder_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         imem_read;
    logic [15:0]  imem_address;
    logic         imem_resp;
    logic [15:0]  imem_rdata;
    logic         pmem_read;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  miss_count;

    always #5 clk = ~clk;

    icache_responder dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .miss_count   (miss_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    bit check_en  = 1'b0;
    bit auto_resp = 1'b1;
    bit rand_lat  = 1'b0;
    bit preload   = 1'b0;
    int resp_lat  = 1;
    int wait_cnt  = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    // Backing memory contents: a simple function of line address and word number.
    function automatic logic [15:0] mem_word(input logic [15:0] la, input int k);
        return 16'((la ^ 16'h1234) + 16'(k) * 16'h1111);
    endfunction

    function automatic lc3b_line mem_line(input logic [15:0] la);
        lc3b_line l;
        for (int k = 0; k < 8; k++) l[16*k +: 16] = mem_word(la, k);
        return l;
    endfunction

    // Model: each set remembers which line address it holds.
    bit          m_valid [8];
    logic [15:0] m_base  [8];
    bit          m_busy  = 1'b0;
    logic [15:0] m_paddr = 16'h0000;
    logic [15:0] m_cnt   = 16'h0000;

    function automatic int a_idx(input logic [15:0] a);
        return int'((a >> 4) % 16'd8);
    endfunction

    function automatic int a_off(input logic [15:0] a);
        return int'((a >> 1) % 16'd8);
    endfunction

    function automatic bit m_hit();
        int i;
        i = a_idx(imem_address);
        return !m_busy && imem_read && m_valid[i] && (m_base[i] == (imem_address & 16'hFFF0));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_valid[i] <= 1'b0;
            m_busy  <= 1'b0;
            m_paddr <= 16'h0000;
            m_cnt   <= 16'h0000;
        end else begin
            if (preload) m_cnt <= 16'hFFFE;
            if (m_busy) begin
                if (pmem_resp) begin
                    m_valid[a_idx(m_paddr)] <= 1'b1;
                    m_base[a_idx(m_paddr)]  <= m_paddr;
                    m_busy                  <= 1'b0;
                end
            end else if (imem_read && !m_hit()) begin
                m_busy  <= 1'b1;
                m_paddr <= imem_address & 16'hFFF0;
                if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            end
        end
    end

    // Compare process: all outputs against the model, mid-cycle.
    always @(negedge clk) begin
        #2;
        if (check_en) begin
            bit h;
            h = m_hit();
            chk("imem_resp", 16'(imem_resp), 16'(h));
            chk("imem_rdata", imem_rdata,
                h ? mem_word(m_base[a_idx(imem_address)], a_off(imem_address)) : 16'h0000);
            chk("pmem_read", 16'(pmem_read), 16'(m_busy));
            chk("pmem_address", pmem_address, m_paddr);
            chk("miss_count", miss_count, m_cnt);
        end
    end

    // One cycle: advance to the falling edge and run the pmem responder.
    task automatic step();
        @(negedge clk);
        pmem_resp = 1'b0;
        if (auto_resp && pmem_read) begin
            wait_cnt++;
            if (wait_cnt >= resp_lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = mem_line(pmem_address);
                wait_cnt   = 0;
                if (rand_lat) resp_lat = int'($urandom_range(4, 1));
            end
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic cyc(input logic rd, input logic [15:0] a);
        step();
        imem_read    = rd;
        imem_address = a;
    endtask

    // Miss on `a`, keep requesting until the hit; n = hit cycle relative to the miss cycle.
    task automatic miss_fill(input logic [15:0] a, output int n);
        int k;
        cyc(1'b1, a); #2;
        chk("miss_no_resp", 16'(imem_resp), 16'h0000);
        cyc(1'b1, a); #2;
        chk("fill_read", 16'(pmem_read), 16'h0001);
        chk("fill_addr", pmem_address, a & 16'hFFF0);
        k = 0;
        while (!imem_resp && k < 40) begin
            cyc(1'b1, a); #2;
            k++;
        end
        chk("fill_done", 16'(imem_resp), 16'h0001);
        n = k + 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; imem_read = 1'b0; imem_address = 16'h0000;
        pmem_resp = 1'b0; pmem_rdata = '0;
        cyc(1'b0, 16'h0000);
        cyc(1'b0, 16'h0000);
        check_en = 1'b1;
        #2;
        chk("rst_imem_resp", 16'(imem_resp), 16'h0000);
        chk("rst_pmem_read", 16'(pmem_read), 16'h0000);
        chk("rst_pmem_addr", pmem_address, 16'h0000);
        chk("rst_miss_count", miss_count, 16'h0000);
        rst = 1'b0;

        // Cold miss at 0x0000 with a five-cycle fill.
        resp_lat = 5;
        miss_fill(16'h0000, n);
        chk("t1_hit_cycle", 16'(n), 16'd6);
        chk("t1_rdata", imem_rdata, 16'h1234);
        chk("t1_count", miss_count, 16'h0001);

        // Hits within the filled line.
        cyc(1'b1, 16'h000E); #2;
        chk("t2_word7", imem_rdata, 16'h89AB);
        chk("t2_no_pmem", 16'(pmem_read), 16'h0000);
        cyc(1'b1, 16'h0005); #2;
        chk("t2_word2", imem_rdata, 16'h3456);

        // Conflict on set 0.
        resp_lat = 2;
        miss_fill(16'h0080, n);
        chk("t3_rdata", imem_rdata, 16'h12B4);
        miss_fill(16'h0000, n);
        chk("t3_count", miss_count, 16'h0003);

        // Request drops and address changes mid-fill.
        resp_lat = 6;
        cyc(1'b1, 16'h0010);
        cyc(1'b0, 16'h0200); #2;
        chk("t4_addr_a", pmem_address, 16'h0010);
        repeat (3) cyc(1'b0, 16'h0200);
        #2;
        chk("t4_addr_b", pmem_address, 16'h0010);
        n = 0;
        while (pmem_read && n < 40) begin
            cyc(1'b0, 16'h0200); #2;
            n++;
        end
        chk("t4_fill_end", 16'(pmem_read), 16'h0000);
        cyc(1'b1, 16'h0010); #2;
        chk("t4_hit", 16'(imem_resp), 16'h0001);
        chk("t4_rdata", imem_rdata, 16'h1224);

        // Reset two cycles into a fill; a late pmem_resp is ignored.
        auto_resp = 1'b0;
        cyc(1'b1, 16'h0020);
        cyc(1'b0, 16'h0020);
        cyc(1'b0, 16'h0020);
        rst = 1'b1;
        cyc(1'b0, 16'h0020);
        rst = 1'b0;
        #2;
        chk("t5_read_off", 16'(pmem_read), 16'h0000);
        chk("t5_count_clr", miss_count, 16'h0000);
        cyc(1'b0, 16'h0000);
        pmem_resp  = 1'b1;
        pmem_rdata = mem_line(16'h0020);
        cyc(1'b0, 16'h0000); #2;
        chk("t5_late_resp", 16'(pmem_read), 16'h0000);
        auto_resp = 1'b1;
        resp_lat  = 1;
        miss_fill(16'h0000, n);
        miss_fill(16'h0020, n);
        chk("t5_count", miss_count, 16'h0002);

        // Saturation from a preloaded counter.
        cyc(1'b0, 16'h0000);
        check_en = 1'b0;
        preload  = 1'b1;
        force dut.miss_cnt_q = 16'hFFFE;
        cyc(1'b0, 16'h0000);
        release dut.miss_cnt_q;
        preload  = 1'b0;
        check_en = 1'b1;
        #2;
        chk("t6_preload", miss_count, 16'hFFFE);
        miss_fill(16'h0300, n);
        chk("t6_max", miss_count, 16'hFFFF);
        miss_fill(16'h0400, n);
        chk("t6_hold", miss_count, 16'hFFFF);

        // Random traffic over a few tags so hits and conflicts both occur.
        rand_lat = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            logic [15:0] a;
            a = 16'({$urandom_range(3, 0), 3'($urandom_range(7, 0)),
                     3'($urandom_range(7, 0)), 1'($urandom_range(1, 0))});
            cyc(1'($urandom_range(9, 0) < 7), a);
            rst = ($urandom_range(499, 0) == 0);
        end
        rst = 1'b0;
        repeat (10) cyc(1'b0, 16'h0000);

        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
